// File: rtl/rptr_empty_lvl_if.sv
// Read-side handshake bundle between the FIFO read logic and its consumer.
// The slave modport is the pointer/flag controller; master is whoever drives reads.
interface rptr_empty_lvl_if #(
    parameter int ADDRSIZE = 4
);
    logic [ADDRSIZE:0]   rq2_wptr;
    logic                rinc;
    logic                rflush;
    logic [ADDRSIZE:0]   ae_thresh;
    logic [ADDRSIZE:0]   rptr;
    logic [ADDRSIZE-1:0] raddr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
    logic                runderflow;

    modport master (
        output rq2_wptr, rinc, rflush, ae_thresh,
        input  rptr, raddr, rempty, raempty, rlevel, runderflow
    );

    modport slave (
        input  rq2_wptr, rinc, rflush, ae_thresh,
        output rptr, raddr, rempty, raempty, rlevel, runderflow
    );
endinterface

// File: rtl/rptr_empty_lvl.sv
// Read-domain pointer/flag controller for the async FIFO: binary/Gray read pointer,
// empty, fill level, almost-empty, sticky underflow and a read-side flush.
module rptr_empty_lvl #(
    parameter int ADDRSIZE = 4
) (
    input logic              rclk,
    input logic              rrst_n,
    rptr_empty_lvl_if.slave  bus
);
    logic [ADDRSIZE:0] rbin;
    logic [ADDRSIZE:0] rgray;
    logic [ADDRSIZE:0] level_q;
    logic              empty_q;
    logic              aempty_q;
    logic              uflow_q;

    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] rbnext;
    logic [ADDRSIZE:0] rgnext;
    logic [ADDRSIZE:0] lvl_next;
    logic              rd_ok;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
        logic [ADDRSIZE:0] b;
        b = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign wbin     = gray2bin(bus.rq2_wptr);
    assign rd_ok    = bus.rinc & ~empty_q;
    assign rbnext   = bus.rflush ? wbin : rbin + {{ADDRSIZE{1'b0}}, rd_ok};
    assign rgnext   = rbnext ^ (rbnext >> 1);
    assign lvl_next = wbin - rbnext;

    // Flags and level share rbnext and the synchronised write pointer, so they never disagree.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            rbin     <= '0;
            rgray    <= '0;
            empty_q  <= 1'b1;
            aempty_q <= 1'b1;
            level_q  <= '0;
            uflow_q  <= 1'b0;
        end else begin
            rbin     <= rbnext;
            rgray    <= rgnext;
            empty_q  <= (rgnext == bus.rq2_wptr);
            aempty_q <= (lvl_next <= bus.ae_thresh);
            level_q  <= lvl_next;
            uflow_q  <= uflow_q | (bus.rinc & empty_q & ~bus.rflush);
        end
    end

    assign bus.rptr       = rgray;
    assign bus.raddr      = rbin[ADDRSIZE-1:0];
    assign bus.rempty     = empty_q;
    assign bus.raempty    = aempty_q;
    assign bus.rlevel     = level_q;
    assign bus.runderflow = uflow_q;
endmodule
